packet_tick_gen: RTL

PACKET_TICK_GEN -- requirements
Module: packet_tick_gen

---
 rtl/packet_tick_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/packet_tick_gen.sv
// rtl/packet_tick_gen.sv - multi-channel programmable periodic / one-shot tick generator
module packet_tick_gen #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 24,
    parameter int DEF_PERIOD = 10000000
) (
    input  logic                                         CLK,
    input  logic                                         RESETN,
    input  logic [NUM_CH-1:0]                            ENABLE,
    input  logic [NUM_CH-1:0]                            ONESHOT,
    input  logic                                         SYNC,
    input  logic                                         CFG_WE,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] CFG_CH,
    input  logic [CNT_W-1:0]                             CFG_PERIOD,
    output logic [NUM_CH-1:0]                            TICK,
    output logic [NUM_CH-1:0]                            BUSY
);

    localparam int              CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q [NUM_CH];
    state_t             state_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [CNT_W-1:0]   act_q   [NUM_CH];
    logic [CNT_W-1:0]   act_d   [NUM_CH];
    logic [CNT_W-1:0]   pend_q  [NUM_CH];
    logic [CNT_W-1:0]   pend_d  [NUM_CH];
    logic [CNT_W-1:0]   term    [NUM_CH];
    logic [NUM_CH-1:0]  tick_q;
    logic [NUM_CH-1:0]  tick_d;
    logic [NUM_CH-1:0]  busy_q;
    logic [NUM_CH-1:0]  busy_d;
    logic [NUM_CH-1:0]  wr_hit;

    // Terminal count per channel; periods of 0 and 1 both collapse to a one-cycle period.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            term[i] = (act_q[i] <= CNT_W'(1)) ? '0 : act_q[i] - CNT_W'(1);
        end
    end

    // Write decode: only indices that name a real channel can match, so out-of-range writes vanish.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = CFG_WE && (CFG_CH == CH_W'(i));
        end
    end

    // Per-channel next state: disable > SYNC > terminal count > increment.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            act_d[i]   = act_q[i];
            pend_d[i]  = wr_hit[i] ? CFG_PERIOD : pend_q[i];
            tick_d[i]  = 1'b0;

            case (state_q[i])
                ST_IDLE: begin
                    cnt_d[i] = '0;
                    act_d[i] = pend_q[i];
                    if (ENABLE[i]) begin
                        state_d[i] = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!ENABLE[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (SYNC) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == term[i]) begin
                        cnt_d[i]  = '0;
                        tick_d[i] = 1'b1;
                        act_d[i]  = pend_q[i];
                        if (ONESHOT[i]) begin
                            state_d[i] = ST_DONE;
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_d[i] = '0;
                    act_d[i] = pend_q[i];
                    if (!ENABLE[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase

            busy_d[i] = (state_d[i] == ST_RUN);
        end
    end

    // State, counters, period registers and registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                act_q[i]   <= DEF_P;
                pend_q[i]  <= DEF_P;
            end
            tick_q <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                act_q[i]   <= act_d[i];
                pend_q[i]  <= pend_d[i];
            end
            tick_q <= tick_d;
            busy_q <= busy_d;
        end
    end

    assign TICK = tick_q;
    assign BUSY = busy_q;

endmodule
